alu_ctl_exec: RTL
=================

Name: alu_ctl_exec

Overview:
- Parametrised successor to the combinational ALU control decoder: decodes ALUOp/FuncCode, executes the operation, and registers the result.
- Adds a multi-cycle unsigned shift-add multiplier with HI/LO registers and a valid/ready handshake.
- Sits in the EX stage of the MIPS datapath; the upstream stage stalls while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4); MULT latency = WIDTH cycles.
- SLT_SIGNED, 1, 1 = SLT compares as two's complement; 0 = unsigned compare.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  unit accepts an operation this cycle (accept = in_valid & in_ready)
- ALUOp  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use FuncCode), 11 illegal
- FuncCode  in  6  MIPS funct field
- a  in  WIDTH  operand A (rs)
- b  in  WIDTH  operand B (rt/imm)
- ALUCtl  out  4  registered decoded control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULT, 1001 MFHI, 1010 MFLO, 1111 illegal
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- out_valid  out  1  one-cycle pulse: result/zero/ALUCtl/illegal are valid
- illegal  out  1  op was undecodable (qualified by out_valid)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result, hi, lo = 0; ALUCtl = 0000; zero = 1; out_valid = 0; illegal = 0; in_ready = 1 after reset release.
- Decode for ALUOp=10: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR, 011001 MULT (multu), 010000 MFHI, 010010 MFLO; any other funct is illegal. ALUOp=11 is illegal.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag. SLT result = {WIDTH-1 zeros, lt}.
- FSM states:
  - IDLE: in_ready=1. On accept of a single-cycle op (including MFHI/MFLO/illegal), register the outputs at that edge; out_valid=1 in the next cycle; stay in IDLE. Back-to-back accepts give one result per cycle. Illegal ops give result=0, ALUCtl=1111, illegal=1.
  - IDLE on accept of MULT: latch a and b, clear the accumulator, counter=0, go to MUL.
  - MUL: in_ready=0. Each cycle, if multiplier LSB=1 add the multiplicand to the upper accumulator, then shift right by one; counter increments. When counter reaches WIDTH-1 on a clock edge, go to DONE.
  - DONE: write hi/lo = 2*WIDTH-bit product; result = lo; ALUCtl=1000; out_valid=1 for one cycle; in_ready=0; next state IDLE.
- MULT total latency: accept edge to out_valid = WIDTH+1 cycles.
- hi/lo change only in DONE. MFHI/MFLO issued directly after MULT completes read the new values.
- in_valid while in_ready=0 is ignored; the operation is not queued.
- Reset mid-MULT aborts the operation; hi/lo return to 0.
- zero is computed from the registered result value for every op, including MULT (lo==0).

Optional Feature:
- Macro ALU_CTL_DIV_EN.
- Defined: funct 011011 (divu) is decoded with ALUCtl=1011. It runs a restoring division using the same MUL-style state (DIV) for WIDTH cycles, then DONE with lo=quotient and hi=remainder.
- Divide by zero gives lo = all ones, hi = a, illegal=0.
- Not defined: funct 011011 is illegal (ALUCtl=1111, illegal=1, single cycle); no divider logic is synthesised.

Test Plan:
- Reset mid-stream: assert rst_n=0 during a MULT -> outputs at reset values immediately (asynchronously); in_ready=1 after release; hi=lo=0.
- Single-cycle ops, WIDTH=32, back-to-back: ALUOp=10 with ADD a=7, b=5; SUB a=5, b=5; SLT a=-1, b=1 -> results 12, 0, 1 on three consecutive out_valid cycles; zero=1 only for SUB; ALUCtl 0010, 0110, 0111.
- LW/BEQ paths: ALUOp=00, a=0x100, b=4 -> result 0x104. ALUOp=01, a=b=0x55 -> zero=1, ALUCtl=0110.
- MULT: a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept; hi=1, lo=0xFFFFFFFE; in_ready=0 throughout. Follow with MFHI -> result=1, then MFLO -> 0xFFFFFFFE.
- Illegal ops: ALUOp=11, and ALUOp=10 with funct 111111 -> illegal=1, ALUCtl=1111, result=0, one-cycle latency. in_valid pulsed during a MULT is dropped: no extra out_valid.
- With ALU_CTL_DIV_EN: divu a=100, b=7 -> lo=14, hi=2. divu b=0 -> lo=0xFFFFFFFF, hi=a. Without the macro, divu -> illegal=1.

Source files
------------

// File: rtl/alu_ctl_exec.sv
// EX-stage ALU: decodes ALUOp/FuncCode, runs single-cycle ops and a WIDTH-cycle shift-add
// unsigned multiplier into HI/LO. Define ALU_CTL_DIV_EN to add a restoring divu on the same datapath.
module alu_ctl_exec #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SLT_SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       ALUCtl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_MULT = 4'b1000;
  localparam logic [3:0] CTL_MFHI = 4'b1001;
  localparam logic [3:0] CTL_MFLO = 4'b1010;
  localparam logic [3:0] CTL_ILL  = 4'b1111;
`ifdef ALU_CTL_DIV_EN
  localparam logic [3:0] CTL_DIVU = 4'b1011;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_CTL_DIV_EN
    , S_DIV = 2'd3
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [3:0]             ctl_c;
  logic [WIDTH-1:0]       alu_c;
  logic                   lt_c, long_c, accept_c;
  logic [2*WIDTH-1:0]     acc, acc_d, mul_step_c;
  logic [WIDTH:0]         mul_upper_c;
  logic [WIDTH-1:0]       mcand, mcand_d;
  logic [CW-1:0]          cnt, cnt_d;
  logic [WIDTH-1:0]       result_d, hi_d, lo_d;
  logic [3:0]             ctl_d;
  logic                   zero_d, ill_d, ov_d;
`ifdef ALU_CTL_DIV_EN
  logic                   is_div, is_div_d;
  logic [WIDTH:0]         rem_shift_c;
  logic [WIDTH-1:0]       rem_sub_c;
  logic                   ge_c;
  logic [2*WIDTH-1:0]     div_step_c;
`endif

  assign accept_c = in_valid & in_ready;

  // Control decode
  always_comb begin
    ctl_c = CTL_ILL;
    case (ALUOp)
      2'b00: ctl_c = CTL_ADD;
      2'b01: ctl_c = CTL_SUB;
      2'b10: begin
        case (FuncCode)
          6'b100000: ctl_c = CTL_ADD;
          6'b100010: ctl_c = CTL_SUB;
          6'b100100: ctl_c = CTL_AND;
          6'b100101: ctl_c = CTL_OR;
          6'b101010: ctl_c = CTL_SLT;
          6'b100111: ctl_c = CTL_NOR;
          6'b011001: ctl_c = CTL_MULT;
          6'b010000: ctl_c = CTL_MFHI;
          6'b010010: ctl_c = CTL_MFLO;
`ifdef ALU_CTL_DIV_EN
          6'b011011: ctl_c = CTL_DIVU;
`endif
          default:   ctl_c = CTL_ILL;
        endcase
      end
      default: ctl_c = CTL_ILL;
    endcase
  end

  // Single-cycle execute
  always_comb begin
    lt_c = (SLT_SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
    long_c = (ctl_c == CTL_MULT);
`ifdef ALU_CTL_DIV_EN
    if (ctl_c == CTL_DIVU) long_c = 1'b1;
`endif
    case (ctl_c)
      CTL_AND:  alu_c = a & b;
      CTL_OR:   alu_c = a | b;
      CTL_ADD:  alu_c = a + b;
      CTL_SUB:  alu_c = a - b;
      CTL_SLT:  alu_c = {{(WIDTH-1){1'b0}}, lt_c};
      CTL_NOR:  alu_c = ~(a | b);
      CTL_MFHI: alu_c = hi;
      CTL_MFLO: alu_c = lo;
      default:  alu_c = '0;
    endcase
  end

  // Multiply step: acc = {partial product, remaining multiplier bits}
  assign mul_upper_c = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_step_c  = {mul_upper_c, acc[WIDTH-1:1]};

`ifdef ALU_CTL_DIV_EN
  // Restoring divide step: acc = {remainder, dividend/quotient}; divisor 0 yields q=all ones, r=a
  assign rem_shift_c = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge_c        = rem_shift_c >= {1'b0, mcand};
  assign rem_sub_c   = rem_shift_c[WIDTH-1:0] - mcand;
  assign div_step_c  = {(ge_c ? rem_sub_c : rem_shift_c[WIDTH-1:0]), acc[WIDTH-2:0], ge_c};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept_c && long_c) begin
          state_nxt = S_MUL;
`ifdef ALU_CTL_DIV_EN
          if (ctl_c == CTL_DIVU) state_nxt = S_DIV;
`endif
        end
      end
      S_MUL:   if (cnt == CW'(WIDTH-1)) state_nxt = S_DONE;
`ifdef ALU_CTL_DIV_EN
      S_DIV:   if (cnt == CW'(WIDTH-1)) state_nxt = S_DONE;
`endif
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    result_d = result;
    zero_d   = zero;
    ctl_d    = ALUCtl;
    ill_d    = illegal;
    ov_d     = 1'b0;
    hi_d     = hi;
    lo_d     = lo;
    acc_d    = acc;
    mcand_d  = mcand;
    cnt_d    = cnt;
`ifdef ALU_CTL_DIV_EN
    is_div_d = is_div;
`endif
    case (state)
      S_IDLE: begin
        if (accept_c && long_c) begin
          acc_d   = {{WIDTH{1'b0}}, b};
          mcand_d = a;
          cnt_d   = '0;
`ifdef ALU_CTL_DIV_EN
          is_div_d = (ctl_c == CTL_DIVU);
          if (ctl_c == CTL_DIVU) begin
            acc_d   = {{WIDTH{1'b0}}, a};
            mcand_d = b;
          end
`endif
        end else if (accept_c) begin
          result_d = alu_c;
          zero_d   = (alu_c == '0);
          ctl_d    = ctl_c;
          ill_d    = (ctl_c == CTL_ILL);
          ov_d     = 1'b1;
        end
      end
      S_MUL: begin
        acc_d = mul_step_c;
        cnt_d = cnt + CW'(1);
      end
`ifdef ALU_CTL_DIV_EN
      S_DIV: begin
        acc_d = div_step_c;
        cnt_d = cnt + CW'(1);
      end
`endif
      S_DONE: begin
        hi_d     = acc[2*WIDTH-1:WIDTH];
        lo_d     = acc[WIDTH-1:0];
        result_d = acc[WIDTH-1:0];
        zero_d   = (acc[WIDTH-1:0] == '0);
        ctl_d    = CTL_MULT;
`ifdef ALU_CTL_DIV_EN
        if (is_div) ctl_d = CTL_DIVU;
`endif
        ill_d    = 1'b0;
        ov_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      result    <= '0;
      zero      <= 1'b1;
      ALUCtl    <= CTL_AND;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      mcand     <= '0;
      cnt       <= '0;
`ifdef ALU_CTL_DIV_EN
      is_div    <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      result    <= result_d;
      zero      <= zero_d;
      ALUCtl    <= ctl_d;
      illegal   <= ill_d;
      out_valid <= ov_d;
      hi        <= hi_d;
      lo        <= lo_d;
      acc       <= acc_d;
      mcand     <= mcand_d;
      cnt       <= cnt_d;
`ifdef ALU_CTL_DIV_EN
      is_div    <= is_div_d;
`endif
    end
  end

endmodule
